// File: rtl/pc_sequencer.sv
// Next-PC controller for the 16-bit MIPS fetch stage: selects the PC load value and
// tracks interrupt enable, the saved return address and a RUN/HALT machine.
module pc_sequencer #(
    parameter logic [15:0] RESET_VECTOR = 16'h0000,
    parameter logic [15:0] IRQ_VECTOR   = 16'h0040,
    parameter logic [15:0] PC_STEP      = 16'd1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [15:0] pc_in,
    output logic [15:0] next_pc,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [15:0] branch_target,
    input  logic        jump,
    input  logic [15:0] jump_target,
    input  logic        irq_req,
    output logic        irq_ack,
    input  logic        eret,
    input  logic        halt,
    output logic        halted,
    output logic        flush,
    output logic [15:0] epc
);

    localparam int unsigned PC_W = 16;

    typedef enum logic {
        RUN  = 1'b0,
        HALT = 1'b1
    } state_t;

    state_t            state;
    state_t            state_nx;
    logic              ie;
    logic              ie_nx;
    logic [PC_W-1:0]   epc_nx;
    logic [PC_W-1:0]   seq;
    logic [PC_W-1:0]   tgt;

    // State register; reset wins over any pending decision.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state <= RUN;
            ie    <= 1'b1;
            epc   <= PC_W'(0);
        end else begin
            state <= state_nx;
            ie    <= ie_nx;
            epc   <= epc_nx;
        end
    end

    // Next-PC selection and register updates.
    always_comb begin
        seq      = PC_W'(pc_in + PC_STEP);
        tgt      = jump ? jump_target : (branch_taken ? branch_target : seq);
        state_nx = state;
        ie_nx    = ie;
        epc_nx   = epc;
        next_pc  = pc_in;
        irq_ack  = 1'b0;
        flush    = 1'b0;
        halted   = 1'b0;

        if (!reset) begin
            next_pc = RESET_VECTOR;
        end else begin
            case (state)
                RUN: begin
                    if (stall) begin
                        next_pc = pc_in;
                    end else if (irq_req && ie) begin
                        next_pc = IRQ_VECTOR;
                        irq_ack = 1'b1;
                        flush   = 1'b1;
                        epc_nx  = tgt;
                        ie_nx   = 1'b0;
                    end else if (eret) begin
                        next_pc = epc;
                        ie_nx   = 1'b1;
                        flush   = 1'b1;
                    end else if (halt) begin
                        next_pc  = pc_in;
                        state_nx = HALT;
                    end else if (jump || branch_taken) begin
                        next_pc = tgt;
                        flush   = 1'b1;
                    end else begin
                        next_pc = seq;
                    end
                end
                HALT: begin
                    halted = 1'b1;
                    // Only an enabled interrupt wakes the core; everything else is ignored.
                    if (irq_req && ie) begin
                        next_pc  = IRQ_VECTOR;
                        irq_ack  = 1'b1;
                        flush    = 1'b1;
                        epc_nx   = seq;
                        ie_nx    = 1'b0;
                        state_nx = RUN;
                    end
                end
                default: state_nx = RUN;
            endcase
        end
    end

endmodule
